asp_node: RTL and testbench

- Tagged point-to-point link endpoint between a host and a network.
- TX path: takes host words with a parity bit and checks parity. Good words get a fixed 8-bit tag appended and are sent to the network, then the block waits for an ACK and retransmits on timeout.
- RX path: checks the tag on incoming network words. Words with the matching tag are delivered to the host and acknowledged; all others are dropped silently.

---
 rtl/asp_node_if.sv | 36 +++
 rtl/asp_node.sv | 114 +++++++++++
 tb/tb_asp_node.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/asp_node_if.sv
// Host/network link bundle for asp_node.
// slave = endpoint view, master = host/network side.
interface asp_node_if #(
  parameter int data_size = 32,
  parameter int tag_size  = 8
);
  logic                          data_parity_ready_in;
  logic [data_size:0]            data_parity_in;
  logic                          network_data_ready_in;
  logic                          network_ACK_in;
  logic [data_size+tag_size-1:0] network_data_tag_in;
  logic                          parity_error_out;
  logic                          host_data_ready_out;
  logic [data_size-1:0]          host_data_out;
  logic                          network_data_ready_out;
  logic                          network_ACK_out;
  logic [data_size+tag_size-1:0] network_data_tag_out;

  modport slave (
    input  data_parity_ready_in, data_parity_in,
    input  network_data_ready_in, network_ACK_in,
    input  network_data_tag_in,
    output parity_error_out, host_data_ready_out,
    output host_data_out, network_data_ready_out,
    output network_ACK_out, network_data_tag_out
  );

  modport master (
    output data_parity_ready_in, data_parity_in,
    output network_data_ready_in, network_ACK_in,
    output network_data_tag_in,
    input  parity_error_out, host_data_ready_out,
    input  host_data_out, network_data_ready_out,
    input  network_ACK_out, network_data_tag_out
  );
endinterface

// File: rtl/asp_node.sv
// Tagged link endpoint: parity-checked TX with ACK/retry,
// tag-filtered streaming RX. All outputs registered.
module asp_node #(
  parameter int                  data_size   = 32,
  parameter int                  tag_size    = 8,
  parameter logic [tag_size-1:0] tag_value   = 8'hAB,
  parameter int                  ack_timeout = 16,
  parameter int                  max_retry   = 3
) (
  input  logic      clk,
  input  logic      reset,
  asp_node_if.slave bus
);
  localparam int WW = data_size + tag_size;
  localparam int TW = $clog2(ack_timeout) + 1;
  localparam int RW = $clog2(max_retry + 1) + 1;

  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;

  tx_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [WW-1:0]        tx_word_q, tx_word_d;
  logic                 tx_rdy_q, tx_rdy_d;
  logic                 perr_q, perr_d;
  logic [data_size-1:0] host_q, host_d;
  logic                 host_rdy_q, host_rdy_d;
  logic                 rx_ack_q, rx_ack_d;

  // Next-state for the TX FSM and the stateless RX filter
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    tx_word_d  = tx_word_q;
    tx_rdy_d   = 1'b0;
    perr_d     = 1'b0;
    host_d     = host_q;
    host_rdy_d = 1'b0;
    rx_ack_d   = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (bus.data_parity_ready_in) begin
          if (^bus.data_parity_in) begin
            perr_d = 1'b1;
          end else begin
            tx_word_d = {bus.data_parity_in[data_size-1:0],
                         tag_value};
            tx_rdy_d  = 1'b1;
            timer_d   = '0;
            retry_d   = '0;
            state_d   = TX_WAIT;
          end
        end
      end
      TX_WAIT: begin
        if (bus.network_ACK_in) begin
          state_d = TX_IDLE;
        end else if (timer_q == TW'(ack_timeout - 1)) begin
          timer_d = '0;
          if (retry_q < RW'(max_retry)) begin
            tx_rdy_d = 1'b1;
            retry_d  = retry_q + RW'(1);
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (bus.network_data_ready_in &&
        bus.network_data_tag_in[tag_size-1:0] == tag_value) begin
      host_d     = bus.network_data_tag_in[WW-1:tag_size];
      host_rdy_d = 1'b1;
      rx_ack_d   = 1'b1;
    end
  end

  // State and output registers, async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      tx_word_q  <= '0;
      tx_rdy_q   <= 1'b0;
      perr_q     <= 1'b0;
      host_q     <= '0;
      host_rdy_q <= 1'b0;
      rx_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      tx_word_q  <= tx_word_d;
      tx_rdy_q   <= tx_rdy_d;
      perr_q     <= perr_d;
      host_q     <= host_d;
      host_rdy_q <= host_rdy_d;
      rx_ack_q   <= rx_ack_d;
    end
  end

  assign bus.parity_error_out       = perr_q;
  assign bus.host_data_ready_out    = host_rdy_q;
  assign bus.host_data_out          = host_q;
  assign bus.network_data_ready_out = tx_rdy_q;
  assign bus.network_ACK_out        = rx_ack_q;
  assign bus.network_data_tag_out   = tx_word_q;
endmodule

// File: tb/tb_asp_node.sv
// Self-checking bench for asp_node: vector table,
// timeout/reset sequences and a randomized model check.
module tb_asp_node;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  asp_node_if #(.data_size(32), .tag_size(8)) bus ();

  asp_node dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        perr;
    logic        hrdy;
    logic [31:0] hout;
    logic        nrdy;
    logic        nack;
    logic [39:0] ntag;
  } out_t;

  typedef struct {
    logic        dpr;
    logic [32:0] dp;
    logic        nv;
    logic        ack;
    logic [39:0] nt;
    out_t        exp;
  } vec_t;

  function automatic out_t mk(logic pe, logic hr,
                              logic [31:0] ho, logic nr,
                              logic na, logic [39:0] nt);
    out_t o;
    o = {pe, hr, ho, nr, na, nt};
    return o;
  endfunction

  function automatic out_t act();
    return {bus.parity_error_out, bus.host_data_ready_out,
            bus.host_data_out, bus.network_data_ready_out,
            bus.network_ACK_out, bus.network_data_tag_out};
  endfunction

  task automatic check(string nm, out_t a, out_t e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic drive(logic dpr, logic [32:0] dp, logic nv,
                       logic ack, logic [39:0] nt);
    bus.data_parity_ready_in  = dpr;
    bus.data_parity_in        = dp;
    bus.network_data_ready_in = nv;
    bus.network_ACK_in        = ack;
    bus.network_data_tag_in   = nt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int          m_n;
  bit          m_pend;
  int          m_t0;
  logic [39:0] m_ntag;
  logic [31:0] m_hout;

  function automatic out_t model(logic dpr, logic [32:0] dp,
                                 logic nv, logic ack,
                                 logic [39:0] nt);
    out_t e;
    int   k;
    e = '0;
    if (!m_pend) begin
      if (dpr) begin
        if (^dp) e.perr = 1'b1;
        else begin
          m_pend = 1'b1;
          m_t0   = m_n;
          m_ntag = {dp[31:0], 8'hAB};
          e.nrdy = 1'b1;
        end
      end
    end else if (ack) begin
      m_pend = 1'b0;
    end else if ((m_n - m_t0) % 16 == 0) begin
      k = (m_n - m_t0) / 16;
      if (k <= 3) e.nrdy = 1'b1;
      else m_pend = 1'b0;
    end
    if (nv && nt[7:0] == 8'hAB) begin
      m_hout = nt[39:8];
      e.hrdy = 1'b1;
      e.nack = 1'b1;
    end
    e.hout = m_hout;
    e.ntag = m_ntag;
    m_n++;
    return e;
  endfunction

  vec_t tbl[11];
  int   pulses[$];

  initial begin
    logic        dpr, nv, ack;
    logic [32:0] dp;
    logic [39:0] nt;
    out_t        e;

    tbl[0]  = '{0, 33'h0, 1, 0, 40'h00001234AB,
                mk(0, 1, 32'h1234, 0, 1, 40'h0)};
    tbl[1]  = '{0, 33'h0, 1, 0, 40'h00001234AC,
                mk(0, 0, 32'h1234, 0, 0, 40'h0)};
    tbl[2]  = '{0, 33'h0, 1, 0, 40'h00001234AC,
                mk(0, 0, 32'h1234, 0, 0, 40'h0)};
    tbl[3]  = '{1, {1'b0, 32'h3}, 0, 0, 40'h0,
                mk(0, 0, 32'h1234, 1, 0, 40'h00000003AB)};
    tbl[4]  = '{0, 33'h0, 0, 0, 40'h0,
                mk(0, 0, 32'h1234, 0, 0, 40'h00000003AB)};
    tbl[5]  = '{0, 33'h0, 0, 0, 40'h0,
                mk(0, 0, 32'h1234, 0, 0, 40'h00000003AB)};
    tbl[6]  = '{0, 33'h0, 0, 1, 40'h0,
                mk(0, 0, 32'h1234, 0, 0, 40'h00000003AB)};
    tbl[7]  = '{1, {1'b1, 32'h3}, 0, 0, 40'h0,
                mk(1, 0, 32'h1234, 0, 0, 40'h00000003AB)};
    tbl[8]  = '{1, {1'b1, 32'h1}, 1, 0, 40'hDEADBEEFAB,
                mk(0, 1, 32'hDEADBEEF, 1, 1, 40'h00000001AB)};
    tbl[9]  = '{0, 33'h0, 1, 1, 40'h0000000000,
                mk(0, 0, 32'hDEADBEEF, 0, 0, 40'h00000001AB)};
    tbl[10] = '{0, 33'h0, 0, 1, 40'h0,
                mk(0, 0, 32'hDEADBEEF, 0, 0, 40'h00000001AB)};

    // Reset held 2 cycles with active inputs
    drive(1, {1'b0, 32'h3}, 1, 1, 40'h00001234AB);
    step(); check("rst_c0", act(), '0);
    step(); check("rst_c1", act(), '0);
    drive(0, '0, 0, 0, '0);
    rst_n = 1'b1;
    step(); check("rst_rel", act(), '0);

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].dpr, tbl[i].dp, tbl[i].nv,
            tbl[i].ack, tbl[i].nt);
      step();
      check($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // Timeout / retry sequence
    drive(1, {1'b0, 32'hA5}, 0, 0, '0);
    step();
    check("to_start", act(),
          mk(0, 0, 32'hDEADBEEF, 1, 0, 40'h000000A5AB));
    for (int i = 1; i <= 70; i++) begin
      if (i == 5) drive(1, {1'b1, 32'h3}, 0, 0, '0);
      else if (i == 6) drive(1, {1'b0, 32'h5}, 0, 0, '0);
      else drive(0, '0, 0, 0, '0);
      step();
      if (bus.network_data_ready_out) pulses.push_back(i);
      e = mk(0, 0, 32'hDEADBEEF, 0, 0, 40'h000000A5AB);
      e.nrdy = bus.network_data_ready_out;
      check($sformatf("to_wait%0d", i), act(), e);
    end
    n_chk++;
    if (pulses.size() != 3 || pulses[0] != 16 ||
        pulses[1] != 32 || pulses[2] != 48) begin
      n_err++;
      $display("FAIL to_retry: got %p want '{16,32,48}",
               pulses);
    end
    drive(1, {1'b1, 32'h7}, 0, 0, '0);
    step();
    check("to_new", act(),
          mk(0, 0, 32'hDEADBEEF, 1, 0, 40'h00000007AB));
    drive(0, '0, 0, 0, '0);

    // Reset mid-transaction aborts pending word
    #2 rst_n = 1'b0;
    #1 check("mid_rst", act(), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("post_rst%0d", i), act(), '0);
    end

    // Randomized run against the reference model
    m_n = 0; m_pend = 0; m_t0 = 0;
    m_ntag = '0; m_hout = '0;
    for (int i = 0; i < 1500; i++) begin
      dpr = ($urandom_range(3) == 0);
      dp  = {1'($urandom), 32'($urandom)};
      ack = ($urandom_range(47) == 0);
      nv  = ($urandom_range(1) == 0);
      nt  = {32'($urandom),
             ($urandom_range(1) == 0) ? 8'hAB : 8'($urandom)};
      drive(dpr, dp, nv, ack, nt);
      e = model(dpr, dp, nv, ack, nt);
      step();
      check($sformatf("rand%0d", i), act(), e);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
